alu_commit_stage: RTL and testbench
===================================

Name: alu_commit_stage

Overview:
Stage directly downstream of the 16-bit ALU. It captures the ALU result (S) and flag vector (CVZN) into a 2-entry valid/ready skid buffer. It maintains the architectural flag register, which feeds Cin back to the ALU, and evaluates branch conditions from it. Results drain toward register-file writeback.

Parameters:
WIDTH, 16, data width of result path
RD_W, 3, destination register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream ALU result valid
in_ready  out  1  stage can accept; registered
in_result  in  WIDTH  ALU S
in_cvzn  in  4  ALU flags, [3]=C [2]=V [1]=Z [0]=N
in_flag_we  in  4  per-flag write mask, same bit order as in_cvzn
in_rd  in  RD_W  destination register index
in_rd_we  in  1  destination write enable
out_valid  out  1  writeback entry valid
out_ready  in  1  writeback accepts
out_result  out  WIDTH  head entry result
out_rd  out  RD_W  head entry index
out_rd_we  out  1  head entry write enable
flags_load  in  1  force-load flag register (PS restore)
flags_load_data  in  4  value for force-load
flags  out  4  architectural CVZN register
cin  out  1  flags[3]; feeds ALU Cin
cond_code  in  4  branch condition selector
cond_true  out  1  condition result; combinational from flags

Behaviour:
- Reset (async, rst_n=0): flags=0, buffer EMPTY, out_valid=0, out_result=0, out_rd=0, out_rd_we=0, in_ready=1. Reset mid-transfer discards all buffered entries.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- States: EMPTY(0 entries), ONE(1), FULL(2). Transitions:
  - EMPTY: accept→ONE.
  - ONE: accept&!pop→FULL; pop&!accept→EMPTY; both→ONE.
  - FULL: pop→ONE. in_ready=0, so no accept is possible.
- in_ready is registered and is 1 exactly when the next state is not FULL. It never depends combinationally on out_ready.
- Latency: an entry accepted in cycle t is visible on out_* from cycle t+1 when the buffer was empty.
- Ordering is strict FIFO. The head holds until popped. out_* are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and pop in ONE: the head advances to the new entry. Nothing is lost or duplicated.
- Flag update happens at accept time, not at pop: flags <= (flags & ~in_flag_we) | (in_cvzn & in_flag_we). cin therefore reflects an accepted ADC/SBC result on the following cycle, as dependent ALU ops require.
- flags_load=1 has priority over an accept update in the same cycle: flags <= flags_load_data, and that cycle's in_flag_we is ignored. The entry itself is still accepted.
- flags_load with the buffer FULL is still honoured (flags are independent of buffer occupancy).
- cond_true per cond_code:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0.
- cond_true uses the registered flags only, never the in-flight in_cvzn.
- Result data is passed unmodified. There is no width arithmetic; all fields are stored verbatim.

Test Plan:
- Reset then single accept: in_result=16'h1234, in_rd=5, in_rd_we=1, out_ready=1 → out_valid=1 one cycle later with 16'h1234/5/1; state back to EMPTY after pop.
- Backpressure: out_ready=0, accept 16'h0001, 16'h0002 → in_ready=0 after the 2nd; a 3rd in_valid is held off; raising out_ready drains 0001 then 0002 in order; in_ready returns to 1 the cycle after the first pop.
- Flag mask: flags=4'b0000, accept in_cvzn=4'b1111 with in_flag_we=4'b1010 → flags=4'b1010, cin=1 next cycle.
- Load priority: same cycle flags_load=1, data=4'b0010, and accept in_cvzn=4'b1101, we=4'b1111 → flags=4'b0010, and the entry is still enqueued.
- Conditions: flags C=1 V=0 Z=0 N=1 → EQ=0, HS=1, HI=1, GE=0, LT=1, GT=0, LE=1, AL=1, NV=0.
- Async reset while FULL (rst_n low mid-cycle) → out_valid=0 and flags=0 immediately without a clock edge; in_ready=1 after release; old entries never appear.

Source files
------------

// File: rtl/alu_commit_stage_if.sv
// Bundle between the ALU, the commit stage and register-file writeback:
// result handshakes on both sides plus the flag register and branch-condition signals.
interface alu_commit_stage_if #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [3:0]       in_cvzn;
    logic [3:0]       in_flag_we;
    logic [RD_W-1:0]  in_rd;
    logic             in_rd_we;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RD_W-1:0]  out_rd;
    logic             out_rd_we;

    logic             flags_load;
    logic [3:0]       flags_load_data;
    logic [3:0]       flags;
    logic             cin;
    logic [3:0]       cond_code;
    logic             cond_true;

    // master drives the ALU side and the writeback ready; slave is the commit stage
    modport master (
        output in_valid, in_result, in_cvzn, in_flag_we, in_rd, in_rd_we,
        input  in_ready,
        input  out_valid, out_result, out_rd, out_rd_we,
        output out_ready,
        output flags_load, flags_load_data, cond_code,
        input  flags, cin, cond_true
    );

    modport slave (
        input  in_valid, in_result, in_cvzn, in_flag_we, in_rd, in_rd_we,
        output in_ready,
        output out_valid, out_result, out_rd, out_rd_we,
        input  out_ready,
        input  flags_load, flags_load_data, cond_code,
        output flags, cin, cond_true
    );
endinterface

// File: rtl/alu_commit_stage.sv
// ALU commit stage: a 2-entry skid buffer toward writeback, plus the architectural
// CVZN flag register that feeds Cin back to the ALU and drives branch-condition evaluation.
module alu_commit_stage #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_commit_stage_if.slave  bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             in_ready_q;

    logic [WIDTH-1:0] head_result_q, head_result_d;
    logic [RD_W-1:0]  head_rd_q, head_rd_d;
    logic             head_rd_we_q, head_rd_we_d;

    logic [WIDTH-1:0] tail_result_q, tail_result_d;
    logic [RD_W-1:0]  tail_rd_q, tail_rd_d;
    logic             tail_rd_we_q, tail_rd_we_d;

    logic [3:0]       flags_q, flags_d;

    logic             accept;
    logic             pop;
    logic             out_valid;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // The head slot is what writeback sees; the tail slot only fills under backpressure.
    always_comb begin
        state_d       = state_q;
        head_result_d = head_result_q;
        head_rd_d     = head_rd_q;
        head_rd_we_d  = head_rd_we_q;
        tail_result_d = tail_result_q;
        tail_rd_d     = tail_rd_q;
        tail_rd_we_d  = tail_rd_we_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d       = ST_ONE;
                    head_result_d = bus.in_result;
                    head_rd_d     = bus.in_rd;
                    head_rd_we_d  = bus.in_rd_we;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d       = ST_FULL;
                    tail_result_d = bus.in_result;
                    tail_rd_d     = bus.in_rd;
                    tail_rd_we_d  = bus.in_rd_we;
                end else if (accept && pop) begin
                    head_result_d = bus.in_result;
                    head_rd_d     = bus.in_rd;
                    head_rd_we_d  = bus.in_rd_we;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d       = ST_ONE;
                    head_result_d = tail_result_q;
                    head_rd_d     = tail_rd_q;
                    head_rd_we_d  = tail_rd_we_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // A PS restore wins over the masked flag merge of a result accepted in the same cycle.
    always_comb begin
        flags_d = flags_q;
        if (bus.flags_load) begin
            flags_d = bus.flags_load_data;
        end else if (accept) begin
            flags_d = (flags_q & ~bus.in_flag_we) | (bus.in_cvzn & bus.in_flag_we);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            head_result_q <= '0;
            head_rd_q     <= '0;
            head_rd_we_q  <= 1'b0;
            tail_result_q <= '0;
            tail_rd_q     <= '0;
            tail_rd_we_q  <= 1'b0;
            flags_q       <= 4'b0000;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= (state_d != ST_FULL);
            head_result_q <= head_result_d;
            head_rd_q     <= head_rd_d;
            head_rd_we_q  <= head_rd_we_d;
            tail_result_q <= tail_result_d;
            tail_rd_q     <= tail_rd_d;
            tail_rd_we_q  <= tail_rd_we_d;
            flags_q       <= flags_d;
        end
    end

    // Branch conditions look only at the committed flags, never at in-flight ALU flags.
    logic flagC, flagV, flagZ, flagN;
    logic condTrue;

    assign flagC = flags_q[3];
    assign flagV = flags_q[2];
    assign flagZ = flags_q[1];
    assign flagN = flags_q[0];

    always_comb begin
        condTrue = 1'b0;
        case (bus.cond_code)
            4'd0:    condTrue = flagZ;
            4'd1:    condTrue = !flagZ;
            4'd2:    condTrue = flagC;
            4'd3:    condTrue = !flagC;
            4'd4:    condTrue = flagN;
            4'd5:    condTrue = !flagN;
            4'd6:    condTrue = flagV;
            4'd7:    condTrue = !flagV;
            4'd8:    condTrue = flagC & !flagZ;
            4'd9:    condTrue = !flagC | flagZ;
            4'd10:   condTrue = (flagN == flagV);
            4'd11:   condTrue = (flagN != flagV);
            4'd12:   condTrue = !flagZ & (flagN == flagV);
            4'd13:   condTrue = flagZ | (flagN != flagV);
            4'd14:   condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = head_result_q;
    assign bus.out_rd     = head_rd_q;
    assign bus.out_rd_we  = head_rd_we_q;
    assign bus.flags      = flags_q;
    assign bus.cin        = flags_q[3];
    assign bus.cond_true  = condTrue;

endmodule

// File: tb/tb_alu_commit_stage.sv
// Randomized self-checking bench for alu_commit_stage: a queue-based FIFO model plus
// a flag/condition model, with directed cases for backpressure, flag masking and async reset.
module tb_alu_commit_stage;

    localparam int WIDTH = 16;
    localparam int RD_W  = 3;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             rdWe;
    } entry_t;

    logic clk;
    logic rst_n;

    alu_commit_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

    alu_commit_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount;
    int failCount;

    entry_t     mQueue[$];
    logic [3:0] mFlags;
    logic       mReady;

    // Compare one observed value against the bench's expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Conditions come in complementary pairs; the odd code is the negation of the even one.
    function automatic logic condModel(input logic [3:0] flagsIn, input logic [3:0] code);
        logic c, v, z, n, base;
        c = flagsIn[3];
        v = flagsIn[2];
        z = flagsIn[1];
        n = flagsIn[0];
        case (code >> 1)
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return code[0] ? !base : base;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] result,
                                 input logic [3:0] cvzn, input logic [3:0] flagWe,
                                 input logic [RD_W-1:0] rd, input logic rdWe,
                                 input logic outReady, input logic load,
                                 input logic [3:0] loadData, input logic [3:0] cond);
        bus.in_valid        = valid;
        bus.in_result       = result;
        bus.in_cvzn         = cvzn;
        bus.in_flag_we      = flagWe;
        bus.in_rd           = rd;
        bus.in_rd_we        = rdWe;
        bus.out_ready       = outReady;
        bus.flags_load      = load;
        bus.flags_load_data = loadData;
        bus.cond_code       = cond;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mReady));
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mQueue.size() > 0));
        checkOutput({tag, ".flags"}, 32'(bus.flags), 32'(mFlags));
        checkOutput({tag, ".cin"}, 32'(bus.cin), 32'(mFlags[3]));
        checkOutput({tag, ".cond_true"}, 32'(bus.cond_true), 32'(condModel(mFlags, bus.cond_code)));
        if (mQueue.size() > 0) begin
            checkOutput({tag, ".out_result"}, 32'(bus.out_result), 32'(mQueue[0].result));
            checkOutput({tag, ".out_rd"}, 32'(bus.out_rd), 32'(mQueue[0].rd));
            checkOutput({tag, ".out_rd_we"}, 32'(bus.out_rd_we), 32'(mQueue[0].rdWe));
        end
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, then check.
    task automatic step(input string tag);
        logic   accept, pop;
        entry_t e;
        @(posedge clk);
        accept   = bus.in_valid && mReady;
        pop      = (mQueue.size() > 0) && bus.out_ready;
        e.result = bus.in_result;
        e.rd     = bus.in_rd;
        e.rdWe   = bus.in_rd_we;
        if (pop) void'(mQueue.pop_front());
        if (accept) mQueue.push_back(e);
        if (bus.flags_load) mFlags = bus.flags_load_data;
        else if (accept) mFlags = (mFlags & ~bus.in_flag_we) | (bus.in_cvzn & bus.in_flag_we);
        mReady = (mQueue.size() < 2);
        #1;
        checkState(tag);
    endtask

    task automatic resetModel();
        mQueue.delete();
        mFlags = 4'b0000;
        mReady = 1'b1;
    endtask

    initial begin
        logic [3:0] condList[9];
        logic       condExp[9];

        checkCount = 0;
        failCount  = 0;
        resetModel();
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd14);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset.out_result", 32'(bus.out_result), 32'd0);
        checkOutput("reset.out_rd", 32'(bus.out_rd), 32'd0);
        checkOutput("reset.out_rd_we", 32'(bus.out_rd_we), 32'd0);
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset.flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single accept with writeback ready, visible the following cycle.
        applyStimulus(1'b1, 16'h1234, 4'h0, 4'h0, 3'd5, 1'b1, 1'b1, 1'b0, 4'h0, 4'd0);
        step("single");
        checkOutput("single.result", 32'(bus.out_result), 32'h1234);
        checkOutput("single.rd", 32'(bus.out_rd), 32'd5);
        checkOutput("single.valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0);
        step("single_pop");
        checkOutput("single_pop.valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: fill both slots, hold off a third, then drain in order.
        applyStimulus(1'b1, 16'h0001, 4'h0, 4'h0, 3'd1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd1);
        step("bp_first");
        applyStimulus(1'b1, 16'h0002, 4'h0, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, 4'h0, 4'd1);
        step("bp_second");
        checkOutput("bp_full.in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 16'h0003, 4'h0, 4'h0, 3'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'd1);
        step("bp_held");
        checkOutput("bp_held.result", 32'(bus.out_result), 32'h0001);
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd1);
        step("bp_drain1");
        checkOutput("bp_drain1.result", 32'(bus.out_result), 32'h0002);
        checkOutput("bp_drain1.in_ready", 32'(bus.in_ready), 32'd1);
        step("bp_drain2");
        checkOutput("bp_drain2.valid", 32'(bus.out_valid), 32'd0);

        // Flag mask merge from a cleared register.
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'd2);
        step("mask_clear");
        applyStimulus(1'b1, 16'hBEEF, 4'b1111, 4'b1010, 3'd7, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2);
        step("mask");
        checkOutput("mask.flags", 32'(bus.flags), 32'b1010);
        checkOutput("mask.cin", 32'(bus.cin), 32'd1);

        // Force-load wins over the accept's flag update, but the entry still enqueues.
        applyStimulus(1'b1, 16'hCAFE, 4'b1101, 4'b1111, 3'd4, 1'b1, 1'b0, 1'b1, 4'b0010, 4'd0);
        step("loadprio");
        checkOutput("loadprio.flags", 32'(bus.flags), 32'b0010);
        checkOutput("loadprio.out_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0);
        step("loadprio_drain");

        // Condition table with C=1 V=0 Z=0 N=1, swept without a clock edge.
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b1, 4'b1001, 4'd0);
        step("cond_load");
        bus.flags_load = 1'b0;
        condList = '{4'd0, 4'd2, 4'd8, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        condExp  = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.cond_code = condList[i];
            #1;
            checkOutput($sformatf("cond%0d", condList[i]), 32'(bus.cond_true), 32'(condExp[i]));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom), 4'($urandom),
                          3'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom));
            step("rand");
        end

        // Async reset while FULL takes effect without a clock edge.
        applyStimulus(1'b1, 16'hAAAA, 4'hF, 4'hF, 3'd6, 1'b1, 1'b0, 1'b0, 4'h0, 4'd2);
        step("ar_fill1");
        applyStimulus(1'b1, 16'h5555, 4'hF, 4'hF, 3'd1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd2);
        step("ar_fill2");
        checkOutput("ar_full.in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("ar.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("ar.flags", 32'(bus.flags), 32'd0);
        checkOutput("ar.in_ready", 32'(bus.in_ready), 32'd1);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2);
        step("ar_after1");
        step("ar_after2");
        checkOutput("ar_after.out_valid", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
